// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Size codes, FSM states and the byte-mask helper.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    unique case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replicate / byte enables,
// load shift and sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic [LB-1:0]     lane_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              sign;

  always_comb begin
    be_o = NB'(size_mask(size_i)) << lane_i;
    sh   = rdata_i >> {lane_i, 3'b000};
    unique case (size_i)
      SZ_B: begin
        wdata_o = {NB{wdata_i[7:0]}};
        keep    = DATA_W'(8'hFF);
        sign    = sh[7];
      end
      SZ_H: begin
        wdata_o = {(NB/2){wdata_i[15:0]}};
        keep    = DATA_W'(16'hFFFF);
        sign    = sh[15];
      end
      SZ_W: begin
        wdata_o = {(NB/4){wdata_i[31:0]}};
        keep    = DATA_W'(32'hFFFF_FFFF);
        sign    = sh[31];
      end
      default: begin
        wdata_o = wdata_i;
        keep    = '1;
        sign    = sh[DATA_W-1];
      end
    endcase
    rdata_o = (sh & keep)
            | (~keep & {DATA_W{sign & ~unsigned_i}});
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack memory port, stall, timeout.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 255,
  localparam int NB          = DATA_W / 8,
  localparam int LB          = $clog2(NB),
  localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [NB-1:0]     mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              load_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [LB-1:0]     lane_q;
  logic              ready_q;
  logic              rv_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mreq_q;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] off_mask;
  logic [ADDR_W-1:0] ea;
  logic [LB-1:0]     req_lane;
  logic              illegal;
  logic              nop;
  logic [1:0]        al_size;
  logic [LB-1:0]     al_lane;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  // Low offset bits are dropped so an unchecked misaligned access
  // falls back to the naturally aligned container.
  always_comb begin
    off_mask = (ADDR_W'(1) << req_size) - ADDR_W'(1);
    ea       = req_addr & ~off_mask;
    req_lane = ea[LB-1:0];
    illegal  = (req_load & req_store)
             | ((req_size == SZ_D) && (DATA_W == 32));
    nop      = ~req_load & ~req_store;
    al_size  = (state_q == IDLE) ? req_size : size_q;
    al_lane  = (state_q == IDLE) ? req_lane : lane_q;
    cnt_d    = cnt_q + CW'(1);
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = |(req_addr & off_mask);
`endif

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size_i     (al_size),
    .lane_i     (al_lane),
    .unsigned_i (uns_q),
    .wdata_i    (req_wdata),
    .rdata_i    (mem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      mreq_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            load_q  <= req_load;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_lane;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            if (illegal) begin
              state_q <= RESP;
              rv_q    <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (nop) begin
              state_q <= RESP;
              rv_q    <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            end else if (misalign) begin
              state_q <= RESP;
              rv_q    <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
`endif
            end else begin
              state_q <= ISSUE;
              mreq_q  <= 1'b1;
              we_q    <= req_store;
              be_q    <= al_be;
              addr_q  <= ea & ~ADDR_W'(NB - 1);
              wdata_q <= req_store ? al_wdata : '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            state_q <= RESP;
            mreq_q  <= 1'b0;
            rv_q    <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= load_q ? al_rdata : '0;
          end else if (cnt_d == CW'(TIMEOUT_CYC)) begin
            cnt_q   <= cnt_d;
            state_q <= RESP;
            mreq_q  <= 1'b0;
            rv_q    <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          rv_q    <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          mreq_q  <= 1'b0;
          rv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign stall      = ~ready_q;
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_req    = mreq_q;
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: 32-bit and 64-bit units driven in lockstep against a
// transaction-level model of accept/issue/ack/timeout behaviour.
module tb_mem_access_unit;

  localparam int T32 = 4;
  localparam int T64 = 6;
  localparam int NC  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        r32_ready, r32_rv, r32_err, r32_stall;
  logic [31:0] r32_rdata;
  logic        m32_req, m32_we;
  logic [3:0]  m32_be;
  logic [31:0] m32_addr;
  logic [31:0] m32_wdata;

  logic        r64_ready, r64_rv, r64_err, r64_stall;
  logic [63:0] r64_rdata;
  logic        m64_req, m64_we;
  logic [7:0]  m64_be;
  logic [31:0] m64_addr;
  logic [63:0] m64_wdata;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T32)
  ) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(r32_ready),
    .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(r32_rv), .resp_rdata(r32_rdata),
    .resp_err(r32_err), .stall(r32_stall),
    .mem_req(m32_req), .mem_we(m32_we), .mem_be(m32_be),
    .mem_addr(m32_addr), .mem_wdata(m32_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0])
  );

  mem_access_unit #(
    .ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(T64)
  ) u64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(r64_ready),
    .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r64_rv), .resp_rdata(r64_rdata),
    .resp_err(r64_err), .stall(r64_stall),
    .mem_req(m64_req), .mem_we(m64_we), .mem_be(m64_be),
    .mem_addr(m64_addr), .mem_wdata(m64_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // k = cycle of a one-cycle ack pulse (0: never acked)
  function automatic void model(
    input  int          dw,
    input  int          tmo,
    input  bit          ld,
    input  bit          st,
    input  logic [1:0]  sz,
    input  bit          uns,
    input  logic [31:0] a,
    input  logic [63:0] wd,
    input  logic [63:0] rd,
    input  int          k,
    output int          rc,
    output bit          er,
    output logic [63:0] rdo,
    output int          nq,
    output logic [31:0] ma,
    output logic [7:0]  be,
    output logic [63:0] mw
  );
    int           n, nb, lane;
    logic [31:0]  ea;
    logic [63:0]  dm;
    logic [127:0] m, v;
    n  = 1 << sz;
    nb = dw / 8;
    dm = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    rc = 1; er = 1'b0; rdo = '0; nq = 0;
    ma = '0; be = '0; mw = '0;
    if ((ld && st) || (n > nb)) begin
      er = 1'b1;
      return;
    end
    if (!ld && !st) return;
`ifdef MEM_ALIGN_CHECK_EN
    if (a % n != 0) begin
      er = 1'b1;
      return;
    end
`endif
    ea   = a - (a % n);
    lane = int'(ea % nb);
    ma   = ea - lane;
    be   = 8'(((1 << n) - 1) << lane);
    m    = (128'd1 << (8 * n)) - 1;
    if (st)
      for (int j = 0; j < nb / n; j++)
        mw |= 64'(({64'd0, wd & dm} & m) << (8 * n * j));
    if (k >= 1 && k <= tmo) begin
      rc = k + 1;
      nq = k;
      if (ld) begin
        v = ({64'd0, rd & dm} >> (8 * lane)) & m;
        if (!uns && v[8*n-1]) v |= ~m;
        rdo = 64'(v) & dm;
      end
    end else begin
      rc = tmo + 1;
      nq = tmo;
      er = 1'b1;
    end
  endfunction

  task automatic txn(input bit ld, input bit st, input logic [1:0] sz,
                     input bit uns, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] rd,
                     input int k);
    int          rc[2], nq[2];
    bit          er[2];
    logic [63:0] rdo[2], mw[2];
    logic [31:0] ma[2];
    logic [7:0]  be[2];
    int          g_rc[2], g_nr[2], g_nq[2], sbad[2];
    logic [63:0] g_rd[2], g_wd[2], o_rd[2], o_wd[2];
    logic        g_er[2], g_we[2], o_rv[2], o_er[2], o_rdy[2];
    logic        o_st[2], o_rq[2], o_we[2];
    logic [31:0] g_ma[2], o_ma[2];
    logic [7:0]  g_be[2], o_be[2];
    string       nm[2];
    nm[0] = "u32";
    nm[1] = "u64";
    model(32, T32, ld, st, sz, uns, a, wd, rd, k,
          rc[0], er[0], rdo[0], nq[0], ma[0], be[0], mw[0]);
    model(64, T64, ld, st, sz, uns, a, wd, rd, k,
          rc[1], er[1], rdo[1], nq[1], ma[1], be[1], mw[1]);
    for (int d = 0; d < 2; d++) begin
      g_rc[d] = -1; g_nr[d] = 0; g_nq[d] = 0; sbad[d] = 0;
      g_rd[d] = '0; g_wd[d] = '0; g_er[d] = 1'b0; g_we[d] = 1'b0;
      g_ma[d] = '0; g_be[d] = '0;
    end
    req_load     = ld;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    mem_rdata    = rd;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      o_rv[0] = r32_rv;  o_er[0] = r32_err;  o_rd[0] = 64'(r32_rdata);
      o_rdy[0] = r32_ready; o_st[0] = r32_stall; o_rq[0] = m32_req;
      o_we[0] = m32_we;  o_ma[0] = m32_addr; o_be[0] = 8'(m32_be);
      o_wd[0] = 64'(m32_wdata);
      o_rv[1] = r64_rv;  o_er[1] = r64_err;  o_rd[1] = r64_rdata;
      o_rdy[1] = r64_ready; o_st[1] = r64_stall; o_rq[1] = m64_req;
      o_we[1] = m64_we;  o_ma[1] = m64_addr; o_be[1] = m64_be;
      o_wd[1] = m64_wdata;
      for (int d = 0; d < 2; d++) begin
        if (o_st[d] !== (c >= 1 && c <= rc[d])) sbad[d]++;
        if (o_st[d] !== ~o_rdy[d]) sbad[d]++;
        if (o_rv[d] === 1'b1) begin
          if (g_nr[d] == 0) begin
            g_rc[d] = c; g_er[d] = o_er[d]; g_rd[d] = o_rd[d];
          end
          g_nr[d]++;
        end
        if (o_rq[d] === 1'b1) begin
          if (g_nq[d] == 0) begin
            g_ma[d] = o_ma[d]; g_be[d] = o_be[d];
            g_wd[d] = o_wd[d]; g_we[d] = o_we[d];
          end
          g_nq[d]++;
        end
      end
      req_valid = (c == 0);
      mem_ack   = (k > 0 && c == k);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk({nm[d], ".resp_cycle"}, 64'(g_rc[d]), 64'(rc[d]));
      chk({nm[d], ".resp_count"}, 64'(g_nr[d]), 64'd1);
      chk({nm[d], ".resp_err"}, 64'(g_er[d]), 64'(er[d]));
      chk({nm[d], ".resp_rdata"}, g_rd[d], rdo[d]);
      chk({nm[d], ".req_cycles"}, 64'(g_nq[d]), 64'(nq[d]));
      chk({nm[d], ".stall_errs"}, 64'(sbad[d]), 64'd0);
      if (nq[d] > 0) begin
        chk({nm[d], ".mem_addr"}, 64'(g_ma[d]), 64'(ma[d]));
        chk({nm[d], ".mem_we"}, 64'(g_we[d]), 64'(st));
        if (st) begin
          chk({nm[d], ".mem_be"}, 64'(g_be[d]), 64'(be[d]));
          chk({nm[d], ".mem_wdata"}, g_wd[d], mw[d]);
        end
      end
    end
  endtask

  task automatic rst_mid_issue();
    int nrv;
    logic rq3;
    nrv = 0;
    rq3 = 1'b1;
    req_load = 1'b1; req_store = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h40;
    req_wdata = '0; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      if (c == 3) rq3 = m32_req | m64_req;
      if (r32_rv === 1'b1 || r64_rv === 1'b1) nrv++;
      req_valid = (c == 0);
      rst       = (c == 2);
      mem_ack   = (c == 5);
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    chk("rst.mem_req", 64'(rq3), 64'd0);
    chk("rst.no_resp", 64'(nrv), 64'd0);
    chk("rst.ready", 64'({r32_ready, r64_ready}), 64'd3);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          op;
    rst = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_size = '0; req_unsigned = 1'b0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", 64'({r32_ready, r64_ready}), 64'd3);
    chk("reset.stall", 64'({r32_stall, r64_stall}), 64'd0);
    chk("reset.resp", 64'({r32_rv, r32_err, r64_rv, r64_err}), 64'd0);
    chk("reset.rdata", r64_rdata | 64'(r32_rdata), 64'd0);
    chk("reset.mreq", 64'({m32_req, m32_we, m64_req, m64_we}), 64'd0);
    chk("reset.be", 64'({m32_be, m64_be}), 64'd0);
    chk("reset.addr", {m32_addr, m64_addr}, 64'd0);
    chk("reset.wdata", m64_wdata | 64'(m32_wdata), 64'd0);
    rst = 1'b0;

    txn(0, 1, 2'd0, 0, 32'h1003, 64'hA5, 64'h0, 1);
    txn(1, 0, 2'd1, 0, 32'h2002, 64'h0, 64'h8001_1234, 1);
    txn(1, 0, 2'd1, 1, 32'h2002, 64'h0, 64'h8001_1234, 1);
    txn(1, 0, 2'd2, 0, 32'h100, 64'h0, 64'hCAFE_F00D, 5);
    txn(1, 0, 2'd2, 0, 32'h104, 64'h0, 64'h1, 0);
    txn(1, 0, 2'd2, 0, 32'h108, 64'h0, 64'h7, T32);
    txn(1, 0, 2'd1, 0, 32'h1001, 64'h0, 64'hBEEF_8765, 1);
    txn(0, 1, 2'd1, 0, 32'h1001, 64'h1357, 64'h0, 2);
    rst_mid_issue();
    txn(1, 0, 2'd3, 0, 32'h8, 64'h0, 64'h8000_0000_0000_0001, 2);
    txn(0, 1, 2'd3, 0, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1);
    txn(1, 1, 2'd2, 0, 32'h20, 64'h5, 64'h6, 1);
    txn(0, 0, 2'd0, 0, 32'h24, 64'h5, 64'h6, 1);

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h7;
      txn(op >= 2 && op <= 5 || op == 0, op >= 6 || op == 0, sz,
          1'($urandom_range(0, 1)), a,
          {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 8));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
